clock_divider_ctrl: RTL and testbench
=====================================

// Module: clock_divider_ctrl
//
// PURPOSE
//   Run-time controller for power-of-two clock division. Generates a divided clock (2^N)
//   and a one-cycle period tick from the system clock. A valid/ready config port starts,
//   stops and re-programs the divider. Changes only take effect on period boundaries, so
//   clk_div never shows a runt pulse. Sits beside the static divider chains wherever
//   software must change the slow-domain rate.
//
// PARAMETERS
//   MAX_STAGES  7  maximum division exponent N (largest divide = 2^MAX_STAGES); must be >= 1
//   SEL_W       3  width of stage-select fields; must satisfy 2^SEL_W > MAX_STAGES
//
// PORTS
//   clk          in   1           system clock; all logic is on the rising edge
//   rst          in   1           synchronous, active-high reset
//   cfg_valid    in   1           config request valid
//   cfg_ready    out  1           config can be accepted (handshake = cfg_valid & cfg_ready)
//   cfg_stages   in   SEL_W       requested exponent N (divide ratio 2^N)
//   cfg_enable   in   1           1 = run with cfg_stages, 0 = stop
//   clk_div      out  1           divided clock, driven directly from a flop
//   tick         out  1           flop; 1 in the first cycle of every clk_div period
//   running      out  1           1 while the FSM is in RUN or PENDING
//   cur_stages   out  SEL_W       exponent currently in effect
//
// BEHAVIOUR
//   Reset values
//   - state=IDLE, cnt=0, clk_div=0, tick=0, cur_stages=MAX_STAGES.
//   - Handshakes are ignored while rst=1.
//   Clamping
//   - cfg_stages=0 is treated as 1; cfg_stages>MAX_STAGES is clamped to MAX_STAGES.
//   - The clamped value is what cur_stages reports.
//   Counter and outputs
//   - cnt is MAX_STAGES bits wide. In RUN/PENDING it counts 0..2^N-1 and then wraps to 0.
//   - clk_div=1 while cnt<2^(N-1), else 0. tick=1 only when cnt==0.
//   - In IDLE, clk_div=0 and tick=0.
//   - "Last cycle" means cnt==2^N-1.
//   - cfg_ready = (state != PENDING), decoded from state only.
//   States
//   - IDLE
//     - Handshake with enable=1: cur_stages<=clamp(N), cnt<=0, go RUN.
//       First RUN cycle (T+1 for handshake at T) has clk_div=1, tick=1.
//     - Handshake with enable=0: cur_stages updated, stay IDLE.
//   - RUN
//     - Handshake not in the last cycle: capture stages/enable into pending regs, go PENDING.
//     - Handshake in the last cycle: apply immediately at this boundary (as for PENDING below).
//     - No handshake: keep counting.
//   - PENDING
//     - Counting continues with the old N.
//     - In the last cycle, apply the pending config:
//       - enable=1: cur_stages<=pending, cnt<=0, go RUN (tick=1, clk_div=1 next cycle).
//       - enable=0: go IDLE; clk_div=0 next cycle.
//   Guarantees
//   - Every clk_div period is complete: high 2^(N-1) cycles, then low 2^(N-1) cycles.
//   - A stop never truncates a high or low phase.
//   - A synchronous reset at any point forces the reset values on the next edge; pending
//     config is discarded.
//   - Back-to-back configs: the second is stalled (cfg_ready=0) until the first is applied.
//
// TESTING
//   1. IDLE, cfg N=2 enable=1 at cycle 10
//      -> tick at 11,15,19; clk_div high 11-12, low 13-14; running=1 from 11.
//   2. Running N=3, cfg N=1 at cnt=2
//      -> cfg_ready=0 until the boundary; old period completes (8 cycles);
//         then 2-cycle periods; cur_stages changes 3->1 at the boundary.
//   3. Running N=2, cfg enable=0 in the last cycle (cnt=3)
//      -> immediate apply; IDLE next cycle; clk_div=0; running=0; no truncated pulse.
//   4. cfg_stages=0 -> cur_stages=1, period 2;
//      cfg_stages=7 with MAX_STAGES=5 -> cur_stages=5, period 32.
//   5. rst asserted mid-high-phase with a config pending
//      -> next cycle clk_div=0, tick=0, running=0, cur_stages=MAX_STAGES, cfg_ready=1.
//   6. cfg_valid held high for 3 requests while running
//      -> each accepted only when cfg_ready=1; applied in order, one per period boundary.

Source files
------------

// File: rtl/clock_divider_ctrl.sv
// clock_divider_ctrl: run-time power-of-two clock divider (clk_div, tick) reprogrammed via valid/ready config, changes applied on period boundaries
module clock_divider_ctrl #(
  parameter int MAX_STAGES = 7,
  parameter int SEL_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SEL_W-1:0] cfg_stages,
  input  logic             cfg_enable,
  output logic             clk_div,
  output logic             tick,
  output logic             running,
  output logic [SEL_W-1:0] cur_stages
);
  localparam logic [SEL_W-1:0] MAX_S = SEL_W'(MAX_STAGES);
  typedef enum logic [1:0] {IDLE, RUN, PENDING} state_t;
  state_t                  state_q, state_d;
  logic [MAX_STAGES-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]        cur_q, cur_d, pend_n_q, pend_n_d, clamped, apply_n;
  logic                    pend_en_q, pend_en_d, clk_div_q, clk_div_d, tick_q, tick_d;
  logic                    hs, last, apply_en;
  logic [MAX_STAGES:0]     span_cur, span_d;
  assign cfg_ready  = state_q != PENDING;
  assign running    = state_q != IDLE;
  assign clk_div    = clk_div_q;
  assign tick       = tick_q;
  assign cur_stages = cur_q;
  always_comb begin
    clamped   = cfg_stages == '0 ? SEL_W'(1) : cfg_stages > MAX_S ? MAX_S : cfg_stages;
    hs        = cfg_valid & cfg_ready;
    span_cur  = (MAX_STAGES+1)'(1) << cur_q;
    last      = cnt_q == MAX_STAGES'(span_cur - 1'b1);
    apply_en  = state_q == PENDING ? pend_en_q : cfg_enable;
    apply_n   = state_q == PENDING ? pend_n_q : clamped;
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    cur_d     = cur_q;
    pend_n_d  = pend_n_q;
    pend_en_d = pend_en_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (hs) begin
        cur_d   = clamped;
        state_d = cfg_enable ? RUN : IDLE;
      end
    end else if (last) begin
      cnt_d = '0;
      // Boundary: a pending config, or one arriving right now, takes effect here
      if (state_q == PENDING || hs) begin
        state_d = apply_en ? RUN : IDLE;
        cur_d   = apply_en ? apply_n : cur_q;
      end
    end else if (hs) begin
      state_d   = PENDING;
      pend_n_d  = clamped;
      pend_en_d = cfg_enable;
    end
    // Outputs are registered from next-state values so they line up with cnt_q
    span_d    = (MAX_STAGES+1)'(1) << cur_d;
    clk_div_d = state_d != IDLE && cnt_d < MAX_STAGES'(span_d >> 1);
    tick_d    = state_d != IDLE && cnt_d == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_q     <= MAX_S;
      pend_n_q  <= '0;
      pend_en_q <= 1'b0;
      clk_div_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      pend_n_q  <= pend_n_d;
      pend_en_q <= pend_en_d;
      clk_div_q <= clk_div_d;
      tick_q    <= tick_d;
    end
  end
endmodule

// File: tb/tb_clock_divider_ctrl.sv
// tb_clock_divider_ctrl: directed self-checking bench for clock_divider_ctrl
module tb_clock_divider_ctrl;
  logic       clk = 0, rst = 1, cfg_valid = 0, cfg_enable = 0;
  logic       cfg_ready, clk_div, tick, running;
  logic [2:0] cfg_stages = '0, cur_stages, prev_cur;
  int         n_cmp = 0, n_err = 0;
  logic [2:0] req [3] = '{3'd2, 3'd3, 3'd4};
  int         when_c [3] = '{2, 6, 14};
  clock_divider_ctrl #(.MAX_STAGES(5), .SEL_W(3)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_stages(cfg_stages), .cfg_enable(cfg_enable), .clk_div(clk_div),
    .tick(tick), .running(running), .cur_stages(cur_stages)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic cd, input logic tk, input logic rn, input logic [2:0] cs, input logic rdy);
    chk({tag, ".clk_div"}, 32'(clk_div), 32'(cd));
    chk({tag, ".tick"}, 32'(tick), 32'(tk));
    chk({tag, ".running"}, 32'(running), 32'(rn));
    chk({tag, ".cur_stages"}, 32'(cur_stages), 32'(cs));
    chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(rdy));
  endtask
  task automatic send(input logic [2:0] n, input logic en);
    cfg_valid = 1; cfg_stages = n; cfg_enable = en;
    cyc();
    cfg_valid = 0;
  endtask
  initial begin
    int c, idx, k;
    logic hs;
    cyc(); cyc();
    chk_out("reset", 0, 0, 0, 3'd5, 1);
    rst = 0;
    cyc();
    chk_out("idle", 0, 0, 0, 3'd5, 1);
    // start N=2 from IDLE: period 4, high 2 low 2
    send(3'd2, 1);
    for (int i = 0; i < 8; i++) begin
      chk("n2.clk_div", 32'(clk_div), 32'((i % 4) < 2));
      chk("n2.tick", 32'(tick), 32'((i % 4) == 0));
      chk("n2.running", 32'(running), 1);
      if (i < 7) cyc();
    end
    // now in last cycle (cnt=3): stop applies immediately
    chk("n2.last_ready", 32'(cfg_ready), 1);
    send(3'd2, 0);
    chk_out("stop_last", 0, 0, 0, 3'd2, 1);
    cyc();
    chk_out("stop_last2", 0, 0, 0, 3'd2, 1);
    // N=3 running, reprogram to N=1 at cnt=2
    send(3'd3, 1);
    chk_out("n3.start", 1, 1, 1, 3'd3, 1);
    cyc(); cyc();
    send(3'd1, 1);
    for (int i = 3; i < 8; i++) begin
      chk_out("n3.pending", i < 4, 0, 1, 3'd3, 0);
      if (i < 7) cyc();
    end
    cyc();
    chk_out("n1.first", 1, 1, 1, 3'd1, 1);
    cyc();
    chk_out("n1.second", 0, 0, 1, 3'd1, 1);
    cyc();
    chk_out("n1.third", 1, 1, 1, 3'd1, 1);
    // clamp 0 -> 1
    send(3'd0, 1);
    chk_out("clamp0.pend", 0, 0, 1, 3'd1, 0);
    cyc();
    chk_out("clamp0.apply", 1, 1, 1, 3'd1, 1);
    cyc();
    chk("clamp0.tick_off", 32'(tick), 0);
    cyc();
    chk("clamp0.tick_on", 32'(tick), 1);
    // clamp 7 -> 5, period 32
    send(3'd7, 1);
    cyc();
    chk_out("clamp7.apply", 1, 1, 1, 3'd5, 1);
    for (int i = 1; i < 32; i++) begin
      cyc();
      chk("p32.clk_div", 32'(clk_div), 32'(i < 16));
      chk("p32.tick", 32'(tick), 0);
    end
    cyc();
    chk("p32.wrap_tick", 32'(tick), 1);
    chk("p32.wrap_clk", 32'(clk_div), 1);
    // reset mid-high-phase with a pending config
    send(3'd2, 1);
    chk_out("rst.pending", 1, 0, 1, 3'd5, 0);
    rst = 1;
    cyc();
    chk_out("rst.applied", 0, 0, 0, 3'd5, 1);
    rst = 0;
    cyc(); cyc();
    chk_out("rst.idle", 0, 0, 0, 3'd5, 1);
    // held cfg_valid for three requests while running N=1
    send(3'd1, 1);
    chk_out("b2b.start", 1, 1, 1, 3'd1, 1);
    cfg_valid = 1; cfg_enable = 1; cfg_stages = req[0];
    idx = 0; k = 0; c = 0; prev_cur = cur_stages;
    while (c < 20) begin
      hs = cfg_valid & cfg_ready;
      cyc();
      c++;
      if (hs) begin
        idx++;
        if (idx == 3) cfg_valid = 0;
        else cfg_stages = req[idx];
      end
      if (cur_stages !== prev_cur) begin
        if (k < 3) begin
          chk("b2b.value", 32'(cur_stages), 32'(req[k]));
          chk("b2b.cycle", 32'(c), 32'(when_c[k]));
        end
        chk("b2b.tick", 32'(tick), 1);
        prev_cur = cur_stages;
        k++;
      end
    end
    chk("b2b.accepted", 32'(idx), 3);
    chk("b2b.applied", 32'(k), 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
